int_seq: RTL
============

Name: int_seq

Overview:
- Producer of `control_signals_t` for the 7-cycle reset/NMI/IRQ entry sequence of the 6502 core.
- At each instruction boundary, arbitrates pending interrupt sources.
- Steps a cycle counter and drives the bus-transfer and control lines that push PCH, PCL and P and then load the vector into PC.
- Its `ctl` output is ORed by the top level with the instruction decoder's control word; while `busy=1` the decoder drives all-zero.

Parameters:
- NMI_SYNC_STAGES, 2, flops on the async `nmi_n`/`irq_n` pins before edge/level detection (1..3).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  6502 RDY; low stalls read cycles
- nmi_n  in  1  NMI pin, falling-edge triggered
- irq_n  in  1  IRQ pin, level, active low
- i_flag  in  1  current P.I bit
- insn_done  in  1  decoder pulse: last cycle of current instruction
- ctl  out  control_signals_t  control word for this cycle
- rw  out  1  1 = read, 0 = write
- busy  out  1  sequence active (cycles T1..T7)
- set_i  out  1  pulse: set P.I (cycle T7)
- nmi_ack  out  1  pulse: NMI serviced (cycle T7)

Behaviour:
- Reset state:
  - `state=IDLE`, `ctl`=all zero, `rw=1`, `busy=0`, `set_i=0`, `nmi_ack=0`.
  - `nmi_pend=0`; `rst_pend=1`, so a RESET sequence starts on the first clock after `rst` falls.
- NMI detect: synchronised `nmi_n` 1->0 sets `nmi_pend`. It is cleared only in T7 of an NMI sequence. An edge arriving in the same cycle as the clear re-sets it (set wins).
- IRQ: `irq_pend` = synchronised `!irq_n & !i_flag`, combinational, not latched.
- Start:
  - In IDLE, start when `rst_pend`, or when `insn_done & (nmi_pend | irq_pend)`.
  - Source priority: RESET > NMI > IRQ; the winner is latched into `src`.
- States: IDLE -> T1 -> T2 -> T3 -> T4 -> T5 -> T6 -> T7 -> IDLE. One state per cycle unless stalled.
- T1: `pcl_adl`, `pch_adh`, `adl_abl`, `adh_abh`; dummy read; PC not incremented (`i_pc=0`).
- T2: repeat of T1; dummy read.
- T3, T4, T5 (stack pushes):
  - Address bus = 0x01:S via `s_adl`, `adl_abl`, `z_adh7_1`, `adh_abh`. ADH0 is left precharged high, so ADH = 0x01.
  - Data driven: T3 `pch_db`, T4 `pcl_db`, T5 `p_db`.
  - S decrement each cycle: `s_sb`, `sb_add`, `z_add`, `sums`, `add_sb_6_0`, `add_sb_7`, `sb_s`.
  - `rw=0` for these pushes, except `src`=RESET forces `rw=1`.
- T6: vector low fetch.
  - ADH=0xFF (precharge, no pull-downs), `adh_abh`, `adl_abl`.
  - ADL pull-downs by source: IRQ `z_adl0` (FE); NMI `z_adl0`+`z_adl2` (FA); RESET `z_adl0`+`z_adl1` (FC).
  - `dl_db` loads the byte toward PCL: next cycle `dl_adl`, `adl_pcl`.
- T7: vector high fetch.
  - Same ADH with ADL bit0 released (FF/FB/FD).
  - `dl_adh`, `adh_pch`; `dl_adl`, `adl_pcl` complete the low byte.
  - `set_i=1`; `nmi_ack=1` if `src`=NMI.
- `busy=1` in T1..T7.
- RDY: if `rdy=0` during a read state (T1, T2, T6, T7, or any state when `src`=RESET), `state` holds and `ctl` is repeated. Write states ignore `rdy`.
- Reset mid-sequence: async return to IDLE with `rst_pend=1`; the partial sequence is abandoned; no `set_i`/`nmi_ack` pulse.
- `insn_done` while `busy=1` is ignored.

Optional Feature:
- Macro: INT_SEQ_NMI_HIJACK_EN.
- Defined: if `src`=IRQ and an NMI edge is detected before the end of T5, `src` switches to NMI. T6/T7 then fetch FFFA/FFFB, and `nmi_pend` is cleared at T7.
- Undefined: `src` is frozen at start; NMI stays pending and is serviced after the first instruction of the IRQ handler.

Test Plan:
- Release `rst`, `rdy=1` -> `busy=1` for exactly 7 cycles. T3..T5 have `rw=1`, stack addresses 01S, 01S-1, 01S-2. T6 ADL=FC, T7 ADL=FD. `set_i` pulses in T7.
- `i_flag=0`, `irq_n=0`, `insn_done` pulse -> next cycle T1. T3/T4/T5 write with `pch_db`/`pcl_db`/`p_db`, `rw=0`. Vector FFFE/FFFF. `nmi_ack=0`.
- `nmi_n` falling edge with `irq_n=0`, then `insn_done` -> NMI wins. Vector FFFA/FFFB, `nmi_ack` in T7. IRQ is taken at the next boundary if `i_flag=0`.
- `irq_n=0`, `i_flag=1`, `insn_done` -> stays IDLE, `ctl`=0.
- IRQ sequence with `rdy=0` for 3 cycles entering T2 and again at T4 -> T2 held 3 extra cycles. T4 is not stalled. Total `busy` duration 10 cycles.
- NMI edge during T4 of IRQ sequence:
  - With INT_SEQ_NMI_HIJACK_EN: vector FFFA and `nmi_ack`.
  - Without: vector FFFE, `nmi_pend` stays 1, second sequence to FFFA after the next `insn_done`.
- Assert `rst` in T4 -> outputs return to reset values immediately. After release, a full RESET sequence runs.

Source files
------------

// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer for the 6502 core. It runs the 7-cycle push-and-vector sequence.
// Optional build macro INT_SEQ_NMI_HIJACK_EN lets an NMI take over an IRQ sequence until the end of T5.
package int_seq_pkg;

    typedef struct packed {
        logic pcl_adl;
        logic pch_adh;
        logic adl_abl;
        logic adh_abh;
        logic i_pc;
        logic s_adl;
        logic z_adh7_1;
        logic pch_db;
        logic pcl_db;
        logic p_db;
        logic s_sb;
        logic sb_add;
        logic z_add;
        logic sums;
        logic add_sb_6_0;
        logic add_sb_7;
        logic sb_s;
        logic z_adl0;
        logic z_adl1;
        logic z_adl2;
        logic dl_db;
        logic dl_adl;
        logic adl_pcl;
        logic dl_adh;
        logic adh_pch;
    } control_signals_t;

endpackage

// state | meaning
// IDLE  | waiting for reset request or an interrupt at an instruction boundary
// T1    | dummy read at PC, PC held
// T2    | second dummy read at PC
// T3    | push PCH to 01:S, S decremented
// T4    | push PCL to 01:S, S decremented
// T5    | push P to 01:S, S decremented
// T6    | read vector low byte
// T7    | read vector high byte, load PC, set P.I
module int_seq
    import int_seq_pkg::*;
#(
    parameter int NMI_SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             nmi_n,
    input  logic             irq_n,
    input  logic             i_flag,
    input  logic             insn_done,
    output control_signals_t ctl,
    output logic             rw,
    output logic             busy,
    output logic             set_i,
    output logic             nmi_ack
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET,
        SRC_NMI,
        SRC_IRQ
    } src_t;

    state_t state;
    state_t state_nxt;
    src_t   src;
    src_t   start_src;

    logic [NMI_SYNC_STAGES-1:0] nmi_sync;
    logic [NMI_SYNC_STAGES-1:0] irq_sync;
    logic nmi_s;
    logic irq_s;
    logic nmi_prev;
    logic nmi_fall;
    logic nmi_pend;
    logic irq_pend;
    logic rst_pend;
    logic read_state;
    logic stall;
    logic start;
    logic seq_done;

    // Both pins are asynchronous; the synchronizers idle high (deasserted).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_sync <= '1;
            irq_sync <= '1;
            nmi_prev <= 1'b1;
        end else begin
            nmi_sync[0] <= nmi_n;
            irq_sync[0] <= irq_n;
            for (int i = 1; i < NMI_SYNC_STAGES; i++) begin
                nmi_sync[i] <= nmi_sync[i-1];
                irq_sync[i] <= irq_sync[i-1];
            end
            nmi_prev <= nmi_s;
        end
    end

    assign nmi_s    = nmi_sync[NMI_SYNC_STAGES-1];
    assign irq_s    = irq_sync[NMI_SYNC_STAGES-1];
    assign nmi_fall = nmi_prev & ~nmi_s;
    assign irq_pend = ~irq_s & ~i_flag;

    // Under RESET every cycle is a read, so RDY can stall any of them.
    assign read_state = (state == T1) || (state == T2) || (state == T6) ||
                        (state == T7) || (src == SRC_RESET);
    assign stall      = ~rdy & read_state;
    assign start      = (state == IDLE) &&
                        (rst_pend || (insn_done && (nmi_pend || irq_pend)));
    assign seq_done   = (state == T7) && ~stall;

    always_comb begin
        start_src = SRC_IRQ;
        if (rst_pend) begin
            start_src = SRC_RESET;
        end else if (nmi_pend) begin
            start_src = SRC_NMI;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)  state_nxt = T1;
            T1:   if (!stall) state_nxt = T2;
            T2:   if (!stall) state_nxt = T3;
            T3:   if (!stall) state_nxt = T4;
            T4:   if (!stall) state_nxt = T5;
            T5:   if (!stall) state_nxt = T6;
            T6:   if (!stall) state_nxt = T7;
            T7:   if (!stall) state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_RESET;
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start) begin
                rst_pend <= 1'b0;
                src      <= start_src;
            end
`ifdef INT_SEQ_NMI_HIJACK_EN
            else if ((src == SRC_IRQ) && (nmi_fall || nmi_pend) &&
                     ((state == T1) || (state == T2) || (state == T3) ||
                      (state == T4) || (state == T5))) begin
                src <= SRC_NMI;
            end
`endif

            // A new edge in the clearing cycle must not be lost.
            if (nmi_fall) begin
                nmi_pend <= 1'b1;
            end else if (seq_done && (src == SRC_NMI)) begin
                nmi_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        ctl     = '0;
        rw      = 1'b1;
        busy    = 1'b0;
        set_i   = 1'b0;
        nmi_ack = 1'b0;
        case (state)
            T1, T2: begin
                busy        = 1'b1;
                ctl.pcl_adl = 1'b1;
                ctl.pch_adh = 1'b1;
                ctl.adl_abl = 1'b1;
                ctl.adh_abh = 1'b1;
            end
            T3, T4, T5: begin
                busy           = 1'b1;
                rw             = (src == SRC_RESET);
                ctl.s_adl      = 1'b1;
                ctl.adl_abl    = 1'b1;
                ctl.z_adh7_1   = 1'b1;
                ctl.adh_abh    = 1'b1;
                ctl.s_sb       = 1'b1;
                ctl.sb_add     = 1'b1;
                ctl.z_add      = 1'b1;
                ctl.sums       = 1'b1;
                ctl.add_sb_6_0 = 1'b1;
                ctl.add_sb_7   = 1'b1;
                ctl.sb_s       = 1'b1;
                ctl.pch_db     = (state == T3);
                ctl.pcl_db     = (state == T4);
                ctl.p_db       = (state == T5);
            end
            T6: begin
                busy        = 1'b1;
                ctl.adh_abh = 1'b1;
                ctl.adl_abl = 1'b1;
                ctl.z_adl0  = 1'b1;
                ctl.z_adl1  = (src == SRC_RESET);
                ctl.z_adl2  = (src == SRC_NMI);
                ctl.dl_db   = 1'b1;
            end
            T7: begin
                busy        = 1'b1;
                ctl.adh_abh = 1'b1;
                ctl.adl_abl = 1'b1;
                ctl.z_adl1  = (src == SRC_RESET);
                ctl.z_adl2  = (src == SRC_NMI);
                ctl.dl_adh  = 1'b1;
                ctl.adh_pch = 1'b1;
                ctl.dl_adl  = 1'b1;
                ctl.adl_pcl = 1'b1;
                // Pulse once, on the cycle T7 actually completes.
                set_i       = ~stall;
                nmi_ack     = ~stall && (src == SRC_NMI);
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

endmodule
